// File: rtl/zeroheti_apb_arbiter_pkg.sv
// Shared types and defaults for the two-manager APB arbiter.
package zeroheti_apb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_arb_state_e;

    localparam int unsigned ApbArbTimeoutDefault = 256;
    localparam int unsigned ApbArbNumMgr         = 2;

endpackage

// File: rtl/zeroheti_apb_arbiter_if.sv
// APB signal bundle; NumPorts > 1 carries one lane per manager.
interface zeroheti_apb_arbiter_if #(
    parameter int unsigned NumPorts  = 1,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) ();

    logic [NumPorts-1:0]                psel;
    logic [NumPorts-1:0]                penable;
    logic [NumPorts-1:0]                pwrite;
    logic [NumPorts-1:0][AddrWidth-1:0] paddr;
    logic [NumPorts-1:0][DataWidth-1:0] pwdata;
    logic [NumPorts-1:0][DataWidth-1:0] prdata;
    logic [NumPorts-1:0]                pready;
    logic [NumPorts-1:0]                pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/zeroheti_apb_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the loser only on a contested grant.
module zeroheti_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       valid_o,
    output logic       gnt_o
);

    logic ptr_q;

    always_comb begin
        valid_o = |req_i;
        gnt_o   = 1'b0;
        case (req_i)
            2'b10:   gnt_o = 1'b1;
            2'b11:   gnt_o = ptr_q;
            default: gnt_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (en_i && (&req_i)) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/zeroheti_apb_arbiter.sv
// Shares one APB subordinate bus between two managers with round-robin
// arbitration, clean SETUP/ACCESS re-timing and an ACCESS timeout.
module zeroheti_apb_arbiter
    import zeroheti_apb_arbiter_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = ApbArbTimeoutDefault
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    zeroheti_apb_arbiter_if.slave  mgr,
    zeroheti_apb_arbiter_if.master sub,
    output logic                   timeout_o
);

    localparam int unsigned            CntWidth = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0]    CntLast  = CntWidth'(TimeoutCycles - 1);

    apb_arb_state_e                          state_q;
    logic                                    gnt_q;
    logic [CntWidth-1:0]                     cnt_q;
    logic                                    psel_q;
    logic                                    penable_q;
    logic                                    pwrite_q;
    logic [AddrWidth-1:0]                    paddr_q;
    logic [DataWidth-1:0]                    pwdata_q;
    logic [ApbArbNumMgr-1:0]                 m_pready_q;
    logic [ApbArbNumMgr-1:0]                 m_pslverr_q;
    logic [ApbArbNumMgr-1:0][DataWidth-1:0]  m_prdata_q;
    logic                                    timeout_q;

    logic arb_en;
    logic arb_valid;
    logic arb_gnt;
    logic unused_penable;

    assign arb_en = (state_q == IDLE);

    zeroheti_rr_arb2 u_rr_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (mgr.psel),
        .en_i    (arb_en),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            m_pready_q  <= '0;
            m_pslverr_q <= '0;
            m_prdata_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            m_pready_q <= '0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        gnt_q    <= arb_gnt;
                        pwrite_q <= mgr.pwrite[arb_gnt];
                        paddr_q  <= mgr.paddr[arb_gnt];
                        pwdata_q <= mgr.pwdata[arb_gnt];
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // The terminal count always exits ACCESS, so the increment never wraps.
                    if (sub.pready[0] || (cnt_q == CntLast)) begin
                        psel_q             <= 1'b0;
                        penable_q          <= 1'b0;
                        pwrite_q           <= 1'b0;
                        paddr_q            <= '0;
                        pwdata_q           <= '0;
                        m_pready_q[gnt_q]  <= 1'b1;
                        state_q            <= RESP;
                        if (sub.pready[0]) begin
                            m_prdata_q[gnt_q]  <= sub.prdata[0];
                            m_pslverr_q[gnt_q] <= sub.pslverr[0];
                        end else begin
                            m_pslverr_q[gnt_q] <= 1'b1;
                            timeout_q          <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    m_prdata_q  <= '0;
                    m_pslverr_q <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sub.psel      = psel_q;
    assign sub.penable   = penable_q;
    assign sub.pwrite    = pwrite_q;
    assign sub.paddr[0]  = paddr_q;
    assign sub.pwdata[0] = pwdata_q;

    assign mgr.prdata    = m_prdata_q;
    assign mgr.pready    = m_pready_q;
    assign mgr.pslverr   = m_pslverr_q;

    assign timeout_o      = timeout_q;
    assign unused_penable = ^mgr.penable;

endmodule
